// File: rtl/zbus_cycle_arb_pkg.sv
// zbus_pkg: shared definitions for the Z80 bus cycle arbiter.
//   - bus cycle command encodings and decode helpers
//   - FSM state constants
//   - latched request record
package zbus_pkg;

  localparam logic [1:0] CMD_MEMRD = 2'b00;
  localparam logic [1:0] CMD_MEMWR = 2'b01;
  localparam logic [1:0] CMD_IORD  = 2'b10;
  localparam logic [1:0] CMD_IOWR  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } zreq_t;

  function automatic logic is_io(input logic [1:0] cmd);
    return cmd[1];
  endfunction

  function automatic logic is_wr(input logic [1:0] cmd);
    return cmd[0];
  endfunction

endpackage

// File: rtl/zbus_cycle_arb_if.sv
// zbus_cycle_arb_if: external Z80 bus pins as seen by the bus master.
//   mreq_n/iorq_n/rd_n/wr_n : active-low strobes
//   a                       : address
//   dout/doe                : write data and its output enable (tri-state built above)
//   din                     : data read back from the bus
// master modport = the arbiter, slave modport = the bus / device model.
interface zbus_cycle_arb_if;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  dout;
  logic        doe;
  logic [7:0]  din;

  modport master (
    output mreq_n, iorq_n, rd_n, wr_n, a, dout, doe,
    input  din
  );

  modport slave (
    input  mreq_n, iorq_n, rd_n, wr_n, a, dout, doe,
    output din
  );
endinterface

// File: rtl/zbus_cycle_arb_rr_arb.sv
// zbus_rr_arb: 2-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : request levels
//   en         : arbitration allowed this clock (pointer only moves when en)
//   gnt[1:0]   : one-hot grant (combinational), zero when no request
// After reset requester 0 wins the first tie.
module zbus_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // prefer1 set means requester 1 wins the next tie
  logic prefer1;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prefer1 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)             prefer1 <= 1'b0;
    else if (en && (|req))  prefer1 <= gnt[0];
  end

endmodule

// File: rtl/zbus_cycle_arb.sv
// zbus_cycle_arb: shares one Z80 bus between two requesters, running one
// complete memrd/memwr/iord/iowr cycle per grant.
//   clk, rst_n         : clock, synchronous active-low reset
//   rN_req/cmd/addr/wdata : level request and its cycle description
//   rN_ack             : one-clock completion pulse
//   rdata              : data captured by the last read
//   busy               : high whenever a cycle is in progress
//   bus                : Z80 pins (master side)
// Cycle: IDLE (arbitrate) -> SETUP (1) -> STROBE (STROBE_CYC) -> HOLD (1).
// All outputs come straight from flops.
module zbus_cycle_arb
  import zbus_pkg::*;
#(
  parameter int STROBE_CYC = 2   // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic [1:0]  r0_cmd,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic [1:0]  r1_cmd,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  output logic        r1_ack,
  output logic [7:0]  rdata,
  output logic        busy,
  zbus_cycle_arb_if.master bus
);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  cmd_q;
  logic        gidx;
  logic [1:0]  ack_q;
  logic        mreq_q, iorq_q, rd_q, wr_q, doe_q, busy_q;
  logic [15:0] a_q;
  logic [7:0]  dout_q, rdata_q;

  zreq_t [1:0] rq;
  zreq_t       win;
  logic  [1:0] gnt;

  assign rq[0] = {r0_cmd, r0_addr, r0_wdata};
  assign rq[1] = {r1_cmd, r1_addr, r1_wdata};
  assign win   = gnt[1] ? rq[1] : rq[0];

  zbus_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({r1_req, r0_req}),
    .en    (state == ST_IDLE),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_q   <= CMD_MEMRD;
      gidx    <= 1'b0;
      ack_q   <= '0;
      mreq_q  <= 1'b1;
      iorq_q  <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      doe_q   <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            // latch everything now; later changes on the request side are ignored
            cmd_q  <= win.cmd;
            gidx   <= gnt[1];
            a_q    <= win.addr;
            dout_q <= win.wdata;
            doe_q  <= is_wr(win.cmd);
            busy_q <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          mreq_q <= is_io(cmd_q);
          iorq_q <= ~is_io(cmd_q);
          rd_q   <= is_wr(cmd_q);
          wr_q   <= ~is_wr(cmd_q);
          cnt    <= 4'(STROBE_CYC - 1);
          state  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            // sample din on the same edge the strobe rises
            if (!is_wr(cmd_q)) rdata_q <= bus.din;
            ack_q  <= gidx ? 2'b10 : 2'b01;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          // a/dout keep their values into IDLE; only doe drops
          ack_q  <= '0;
          doe_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign r0_ack     = ack_q[0];
  assign r1_ack     = ack_q[1];
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign bus.mreq_n = mreq_q;
  assign bus.iorq_n = iorq_q;
  assign bus.rd_n   = rd_q;
  assign bus.wr_n   = wr_q;
  assign bus.a      = a_q;
  assign bus.dout   = dout_q;
  assign bus.doe    = doe_q;

endmodule

// File: tb/tb_zbus_cycle_arb.sv
// Bench for zbus_cycle_arb. Two instances (STROBE_CYC = 2 and 1) share the
// same requester inputs and din. A timeline model per instance predicts every
// output each clock: clock k after the arbitration edge is SETUP at k=1,
// strobes low for k=2..S+1, ack/HOLD at k=S+2, back in IDLE at k=S+3.
module tb_zbus_cycle_arb;
  import zbus_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req;
  logic [1:0][1:0]  cmd;
  logic [1:0][15:0] addr;
  logic [1:0][7:0]  wd;
  logic [7:0]       din;

  logic [1:0] ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       busy0, busy1;

  zbus_cycle_arb_if b0();
  zbus_cycle_arb_if b1();
  assign b0.din = din;
  assign b1.din = din;

  zbus_cycle_arb #(.STROBE_CYC(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req[0]), .r0_cmd(cmd[0]), .r0_addr(addr[0]), .r0_wdata(wd[0]), .r0_ack(ack0[0]),
    .r1_req(req[1]), .r1_cmd(cmd[1]), .r1_addr(addr[1]), .r1_wdata(wd[1]), .r1_ack(ack0[1]),
    .rdata(rdata0), .busy(busy0), .bus(b0)
  );

  zbus_cycle_arb #(.STROBE_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req[0]), .r0_cmd(cmd[0]), .r0_addr(addr[0]), .r0_wdata(wd[0]), .r0_ack(ack1[0]),
    .r1_req(req[1]), .r1_cmd(cmd[1]), .r1_addr(addr[1]), .r1_wdata(wd[1]), .r1_ack(ack1[1]),
    .rdata(rdata1), .busy(busy1), .bus(b1)
  );

  // observed outputs, indexed by instance
  logic [1:0][3:0]  o_str;
  logic [1:0]       o_doe, o_busy;
  logic [1:0][1:0]  o_ack;
  logic [1:0][15:0] o_a;
  logic [1:0][7:0]  o_dout, o_rd;
  assign o_str[0]  = {b0.mreq_n, b0.iorq_n, b0.rd_n, b0.wr_n};
  assign o_str[1]  = {b1.mreq_n, b1.iorq_n, b1.rd_n, b1.wr_n};
  assign o_doe     = {b1.doe, b0.doe};
  assign o_busy    = {busy1, busy0};
  assign o_ack[0]  = ack0;
  assign o_ack[1]  = ack1;
  assign o_a[0]    = b0.a;
  assign o_a[1]    = b1.a;
  assign o_dout[0] = b0.dout;
  assign o_dout[1] = b1.dout;
  assign o_rd[0]   = rdata0;
  assign o_rd[1]   = rdata1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model state
  int         S [2] = '{2, 1};
  bit         act [2];
  int         k [2];
  logic [1:0] mcmd [2];
  logic [15:0] ma [2];
  logic [7:0] md [2], mrd [2];
  bit         who [2], last [2];

  // inputs as seen by the coming edge
  logic             p_rst;
  logic [1:0]       p_req;
  logic [1:0][1:0]  p_cmd;
  logic [1:0][15:0] p_addr;
  logic [1:0][7:0]  p_wd;
  logic [7:0]       p_din;

  int cyc = 0;
  logic [1:0] alog0[$];
  int         at1[$];

  task automatic step();
    bit         so, w;
    logic       io, wr;
    logic [3:0] e_str;
    logic [1:0] e_ack;
    p_rst = rst_n; p_req = req; p_cmd = cmd; p_addr = addr; p_wd = wd; p_din = din;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!p_rst) begin
        act[d] = 0; k[d] = 0; mcmd[d] = '0; ma[d] = '0; md[d] = '0; mrd[d] = '0;
        who[d] = 0; last[d] = 1;
      end else if (act[d]) begin
        k[d]++;
        if (k[d] == S[d] + 2 && !mcmd[d][0]) mrd[d] = p_din;
        if (k[d] == S[d] + 3) act[d] = 0;
      end else if (|p_req) begin
        w = (p_req == 2'b11) ? !last[d] : p_req[1];
        last[d] = w; who[d] = w;
        act[d] = 1; k[d] = 1;
        mcmd[d] = p_cmd[w]; ma[d] = p_addr[w]; md[d] = p_wd[w];
      end
      so    = act[d] && k[d] >= 2 && k[d] <= S[d] + 1;
      io    = mcmd[d][1];
      wr    = mcmd[d][0];
      e_str = {~(so & ~io), ~(so & io), ~(so & ~wr), ~(so & wr)};
      e_ack = (act[d] && k[d] == S[d] + 2) ? (who[d] ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("u%0d_strobes@%0d", d, cyc), 32'(o_str[d]), 32'(e_str));
      chk($sformatf("u%0d_doe@%0d", d, cyc), 32'(o_doe[d]), 32'(act[d] && wr));
      chk($sformatf("u%0d_ack@%0d", d, cyc), 32'(o_ack[d]), 32'(e_ack));
      chk($sformatf("u%0d_busy@%0d", d, cyc), 32'(o_busy[d]), 32'(act[d]));
      chk($sformatf("u%0d_a@%0d", d, cyc), 32'(o_a[d]), 32'(ma[d]));
      chk($sformatf("u%0d_dout@%0d", d, cyc), 32'(o_dout[d]), 32'(md[d]));
      chk($sformatf("u%0d_rdata@%0d", d, cyc), 32'(o_rd[d]), 32'(mrd[d]));
      chk($sformatf("u%0d_inv@%0d", d, cyc),
          32'({o_str[d][3] | o_str[d][2], o_str[d][1] | o_str[d][0], ~(o_doe[d] & ~o_str[d][1])}),
          32'd7);
    end
    if (o_ack[0] != 2'b00) alog0.push_back(o_ack[0]);
    if (o_ack[1] != 2'b00) at1.push_back(cyc);
  endtask

  initial begin
    int n, nack;
    logic [7:0] got;
    req = '0; cmd = '0; addr = '0; wd = '0; din = '0; rst_n = 1'b0;

    // reset
    step(); step();
    rst_n = 1'b1;
    step();

    // r0 memrd 1234, din A5 (req presented after edge E0, arbitrated on E0+1)
    din = 8'hA5;
    req[0] = 1'b1; cmd[0] = CMD_MEMRD; addr[0] = 16'h1234;
    step();
    req[0] = 1'b0;
    repeat (6) step();
    chk("t1_rdata_u0", 32'(rdata0), 32'h A5);
    chk("t1_rdata_u1", 32'(rdata1), 32'h A5);

    // r1 iowr 00FE / 5A
    req[1] = 1'b1; cmd[1] = CMD_IOWR; addr[1] = 16'h00FE; wd[1] = 8'h5A;
    step();
    req[1] = 1'b0;
    repeat (6) step();
    chk("t2_dout", 32'(b0.dout), 32'h5A);
    chk("t2_a_kept", 32'(b0.a), 32'h00FE);
    chk("t2_rdata_kept", 32'(rdata0), 32'hA5);

    // both held: strict alternation starting with r0
    alog0.delete();
    cmd[0] = CMD_MEMRD; addr[0] = 16'h1000;
    cmd[1] = CMD_MEMWR; addr[1] = 16'h2000; wd[1] = 8'hC3;
    req = 2'b11;
    repeat (18) step();
    req = 2'b00;
    repeat (8) step();
    chk("t3_ngrants", 32'(alog0.size()), 32'd4);
    got = '0;
    for (int i = 0; i < 4; i++) if (i < alog0.size()) got[2*i +: 2] = alog0[i];
    chk("t3_order", 32'(got), 32'h99);

    // STROBE_CYC=1 back-to-back memwr then iord from r0
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    at1.delete();
    req[0] = 1'b1; cmd[0] = CMD_MEMWR; addr[0] = 16'h4000; wd[0] = 8'h77;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step();
      if (ack1[0]) begin
        n++;
        if (n == 1) begin cmd[0] = CMD_IORD; addr[0] = 16'h4001; end
        else req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    chk("t4_acks", 32'(n), 32'd2);
    chk("t4_gap", (at1.size() >= 2) ? 32'(at1[1] - at1[0]) : 32'd0, 32'd4);
    repeat (6) step();

    // reset during STROBE of a memwr
    din = 8'h3C;
    req[0] = 1'b1; cmd[0] = CMD_MEMWR; addr[0] = 16'h6000; wd[0] = 8'h99;
    step();
    req[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("t5_strobes", 32'({o_str[1], o_str[0]}), 32'hFF);
    chk("t5_doe", 32'(o_doe), 32'd0);
    chk("t5_ack", 32'({ack1, ack0}), 32'd0);
    rst_n = 1'b1;
    step();
    req[0] = 1'b1; cmd[0] = CMD_MEMRD; addr[0] = 16'h6001;
    step();
    req[0] = 1'b0;
    nack = 0;
    repeat (6) begin step(); if (ack0[0]) nack++; end
    chk("t5_after_acks", 32'(nack), 32'd1);
    chk("t5_after_rdata", 32'(rdata0), 32'h3C);

    // request fields change after grant
    req[0] = 1'b1; cmd[0] = CMD_MEMWR; addr[0] = 16'h5555; wd[0] = 8'h33;
    step();
    for (int i = 0; i < 8; i++) begin
      addr[0] = 16'($urandom); wd[0] = 8'($urandom); cmd[0] = 2'($urandom);
      step();
      if (ack0[0]) req[0] = 1'b0;
    end
    req[0] = 1'b0;
    chk("t6_a", 32'(b0.a), 32'h5555);
    chk("t6_dout", 32'(b0.dout), 32'h33);
    repeat (4) step();

    // random traffic, occasional reset
    repeat (400) begin
      req = 2'($urandom);
      for (int d = 0; d < 2; d++) begin
        cmd[d] = 2'($urandom); addr[d] = 16'($urandom); wd[d] = 8'($urandom);
      end
      din   = 8'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
